// File: rtl/cw305_pulpino_mailbox.sv
// ----------------------------------------------------------------------------
// cw305_pulpino_mailbox
// Crypto-clock-domain mailbox between the host register bank and the PULPino
// core. Host pushes arrive as toggles on ext_flags_i[0] and land in an RX
// FIFO; the core sends one TX byte at a time through a toggle handshake that
// the host acknowledges on ext_flags_i[1].
//
// Optional feature macro: PULPINO_MBOX_IRQ_EN (adds IRQEN register and irq_o).
//
// Ports
//   crypto_clk       sole clock
//   rst_n            asynchronous active-low reset
//   ext_data_i[7:0]  host byte, stable while the host push toggle is in flight
//   ext_flags_i[7:0] [0] host push toggle, [1] host TX-ack toggle
//   pulpino_data_o   TX byte toward host
//   pulpino_flags_o  [0] TX toggle, [1] rx_full, [2] rx_ovf, [3] push-ack toggle
//   core_addr_i      byte address, [3:2] selects RXDATA/TXDATA/STATUS/IRQEN
//   core_wr_i/rd_i   single-cycle write/read strobes
//   core_wdata_i     write data
//   core_rdata_o     read data, valid the cycle after core_rd_i
//   irq_o            interrupt (constant 0 unless PULPINO_MBOX_IRQ_EN)
// ----------------------------------------------------------------------------
module cw305_pulpino_mailbox #(
    parameter int unsigned pDEPTH       = 8,
    parameter int unsigned pSYNC_STAGES = 2
) (
    input  logic        crypto_clk,
    input  logic        rst_n,
    input  logic [7:0]  ext_data_i,
    input  logic [7:0]  ext_flags_i,
    output logic [7:0]  pulpino_data_o,
    output logic [7:0]  pulpino_flags_o,
    input  logic [3:0]  core_addr_i,
    input  logic        core_wr_i,
    input  logic        core_rd_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        irq_o
);

    localparam int unsigned AW        = $clog2(pDEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned PRIME_CYC = pSYNC_STAGES + 1;
    localparam int unsigned PW        = $clog2(PRIME_CYC + 1);

    localparam logic [1:0] A_RXDATA = 2'd0;
    localparam logic [1:0] A_TXDATA = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_IRQEN  = 2'd3;

    typedef enum logic {
        TX_IDLE,
        TX_WAIT_ACK
    } tx_state_t;

    logic [pSYNC_STAGES-1:0] r_sync_push;
    logic [pSYNC_STAGES-1:0] r_sync_ack;
    logic                    r_prev_push;
    logic                    r_prev_ack;
    logic [PW-1:0]           r_prime_cnt;

    logic [7:0]              r_mem [pDEPTH];
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [CW-1:0]           r_count;
    logic                    r_ovf;

    tx_state_t               r_tx_state;
    logic [7:0]              r_tx_data;
    logic                    r_tx_flag;
    logic                    r_pa_flag;
    logic                    r_full_flag;
    logic                    r_ovf_flag;
    logic [31:0]             r_rdata;

    logic       w_s_push;
    logic       w_s_ack;
    logic       w_primed;
    logic       w_push_ev;
    logic       w_ack_ev;
    logic [1:0] w_word;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic       w_tx_busy;
    logic       w_pop;
    logic       w_wr_en;
    logic [1:0] w_irqen;
    logic       w_unused;

    assign w_s_push   = r_sync_push[pSYNC_STAGES-1];
    assign w_s_ack    = r_sync_ack[pSYNC_STAGES-1];
    // Sync flops hold reset zeros until the pipeline fills, and prev needs one
    // more cycle to capture the filled value; events are masked until then so a
    // toggle already high before reset is not seen as a push.
    assign w_primed   = (r_prime_cnt == PW'(PRIME_CYC));
    assign w_push_ev  = w_primed & (w_s_push != r_prev_push);
    assign w_ack_ev   = w_primed & (w_s_ack != r_prev_ack);

    assign w_word     = core_addr_i[3:2];
    assign w_rx_empty = (r_count == '0);
    assign w_rx_full  = (r_count == CW'(pDEPTH));
    assign w_tx_busy  = (r_tx_state == TX_WAIT_ACK);
    assign w_pop      = core_rd_i & (w_word == A_RXDATA) & ~w_rx_empty;
    // Full at cycle start drops the push even if a pop frees a slot this cycle.
    assign w_wr_en    = w_push_ev & ~w_rx_full;

    assign w_unused   = ^{core_wdata_i[31:8], core_addr_i[1:0], ext_flags_i[7:2]};

    // Host flag resynchronisation and edge-detect history
    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_push <= '0;
            r_sync_ack  <= '0;
            r_prev_push <= 1'b0;
            r_prev_ack  <= 1'b0;
            r_prime_cnt <= '0;
        end else begin
            r_sync_push <= {r_sync_push[pSYNC_STAGES-2:0], ext_flags_i[0]};
            r_sync_ack  <= {r_sync_ack[pSYNC_STAGES-2:0], ext_flags_i[1]};
            r_prev_push <= w_s_push;
            r_prev_ack  <= w_s_ack;
            if (!w_primed) begin
                r_prime_cnt <= r_prime_cnt + PW'(1);
            end
        end
    end

    // RX FIFO storage (contents are don't-care after reset)
    always_ff @(posedge crypto_clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= ext_data_i;
        end
    end

    // RX FIFO pointers, occupancy and overflow
    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A drop in the same cycle as a clear keeps ovf set.
            if (w_push_ev && w_rx_full) begin
                r_ovf <= 1'b1;
            end else if (core_wr_i && (w_word == A_STATUS) && core_wdata_i[3]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // TX handshake FSM and host-facing flag registers
    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state  <= TX_IDLE;
            r_tx_data   <= 8'h00;
            r_tx_flag   <= 1'b0;
            r_pa_flag   <= 1'b0;
            r_full_flag <= 1'b0;
            r_ovf_flag  <= 1'b0;
        end else begin
            r_full_flag <= w_rx_full;
            r_ovf_flag  <= r_ovf;
            // Push-ack toggles on every push, dropped or not, so the host never stalls.
            if (w_push_ev) begin
                r_pa_flag <= ~r_pa_flag;
            end
            case (r_tx_state)
                TX_IDLE: begin
                    if (core_wr_i && (w_word == A_TXDATA)) begin
                        r_tx_data  <= core_wdata_i[7:0];
                        r_tx_flag  <= ~r_tx_flag;
                        r_tx_state <= TX_WAIT_ACK;
                    end
                end
                TX_WAIT_ACK: begin
                    if (w_ack_ev) begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef PULPINO_MBOX_IRQ_EN
    logic [1:0] r_irqen;
    logic       r_irq;

    // Interrupt enable register and registered interrupt
    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irqen <= 2'b00;
            r_irq   <= 1'b0;
        end else begin
            if (core_wr_i && (w_word == A_IRQEN)) begin
                r_irqen <= core_wdata_i[1:0];
            end
            r_irq <= (r_irqen[0] & ~w_rx_empty) | (r_irqen[1] & ~w_tx_busy);
        end
    end

    assign w_irqen = r_irqen;
    assign irq_o   = r_irq;
`else
    assign w_irqen = 2'b00;
    assign irq_o   = 1'b0;
`endif

    // Registered read port; holds its value between reads
    always_ff @(posedge crypto_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (core_rd_i) begin
            case (w_word)
                A_RXDATA: r_rdata <= w_rx_empty ? 32'h0 : {23'b0, 1'b1, r_mem[r_rptr]};
                A_STATUS: r_rdata <= {16'b0, 8'(r_count), 4'b0, r_ovf, w_tx_busy,
                                      w_rx_full, w_rx_empty};
                A_IRQEN:  r_rdata <= {30'b0, w_irqen};
                default:  r_rdata <= 32'h0;
            endcase
        end
    end

    assign pulpino_data_o  = r_tx_data;
    assign pulpino_flags_o = {4'b0000, r_pa_flag, r_ovf_flag, r_full_flag, r_tx_flag};
    assign core_rdata_o    = r_rdata;

endmodule

// File: tb/tb_cw305_pulpino_mailbox.sv
// ----------------------------------------------------------------------------
// tb_cw305_pulpino_mailbox
// Scoreboard bench: stimulus pushes expected values into sb_q; the monitor
// pops and compares on each read response and on each requested peek of the
// host-facing outputs.
// ----------------------------------------------------------------------------
module tb_cw305_pulpino_mailbox;

    localparam int K_RDATA = 0;
    localparam int K_FLAGS = 1;
    localparam int K_DATA  = 2;
    localparam int K_IRQ   = 3;

    logic        crypto_clk = 1'b0;
    logic        rst_n      = 1'b0;
    logic [7:0]  ext_data_i = 8'h00;
    logic [7:0]  ext_flags_i = 8'h00;
    logic [7:0]  pulpino_data_o;
    logic [7:0]  pulpino_flags_o;
    logic [3:0]  core_addr_i = 4'h0;
    logic        core_wr_i = 1'b0;
    logic        core_rd_i = 1'b0;
    logic [31:0] core_wdata_i = 32'h0;
    logic [31:0] core_rdata_o;
    logic        irq_o;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic r_rd_q = 1'b0;
    logic peek = 1'b0;
    logic finish_chk = 1'b0;
    logic drain_done = 1'b0;

    cw305_pulpino_mailbox #(.pDEPTH(8), .pSYNC_STAGES(2)) dut (
        .crypto_clk      (crypto_clk),
        .rst_n           (rst_n),
        .ext_data_i      (ext_data_i),
        .ext_flags_i     (ext_flags_i),
        .pulpino_data_o  (pulpino_data_o),
        .pulpino_flags_o (pulpino_flags_o),
        .core_addr_i     (core_addr_i),
        .core_wr_i       (core_wr_i),
        .core_rd_i       (core_rd_i),
        .core_wdata_i    (core_wdata_i),
        .core_rdata_o    (core_rdata_o),
        .irq_o           (irq_o)
    );

    always #5 crypto_clk = ~crypto_clk;

    always @(posedge crypto_clk) r_rd_q <= core_rd_i;

    // Monitor: one scoreboard entry per read response and per peek
    always @(negedge crypto_clk) begin
        exp_t        e;
        logic [31:0] act;
        int          n;
        n = int'(r_rd_q) + int'(peek);
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: output presented with no expected value queued");
            end else begin
                e = sb_q.pop_front();
                case (e.kind)
                    K_RDATA: act = core_rdata_o;
                    K_FLAGS: act = {24'b0, pulpino_flags_o};
                    K_DATA:  act = {24'b0, pulpino_data_o};
                    default: act = {31'b0, irq_o};
                endcase
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
        if (finish_chk && !drain_done) begin
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL %s: never observed, expected %h", e.name, e.exp);
            end
            drain_done = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge crypto_clk);
            #1;
        end
    endtask

    task automatic expect_item(input string nm, input int k, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.kind = k;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic core_read(input logic [3:0] a, input logic [31:0] v, input string nm);
        expect_item(nm, K_RDATA, v);
        core_addr_i = a;
        core_rd_i   = 1'b1;
        tick(1);
        core_rd_i   = 1'b0;
    endtask

    task automatic core_write(input logic [3:0] a, input logic [31:0] d);
        core_addr_i  = a;
        core_wdata_i = d;
        core_wr_i    = 1'b1;
        tick(1);
        core_wr_i    = 1'b0;
    endtask

    task automatic peek_chk(input int k, input logic [31:0] v, input string nm);
        expect_item(nm, k, v);
        peek = 1'b1;
        tick(1);
        peek = 1'b0;
    endtask

    task automatic host_push(input logic [7:0] b);
        ext_data_i     = b;
        ext_flags_i[0] = ~ext_flags_i[0];
        tick(5);
    endtask

    task automatic host_ack();
        ext_flags_i[1] = ~ext_flags_i[1];
        tick(5);
    endtask

    // Push toggle timed so the push event coincides with an RXDATA read.
    task automatic push_with_read(input logic [7:0] b, input logic [31:0] v, input string nm);
        ext_data_i     = b;
        ext_flags_i[0] = ~ext_flags_i[0];
        tick(2);
        core_read(4'h0, v, nm);
        tick(3);
    endtask

    initial begin
        // Reset with the push toggle already high
        rst_n       = 1'b0;
        ext_flags_i = 8'h01;
        tick(2);
        peek_chk(K_FLAGS, 32'h00, "rst_flags");
        peek_chk(K_DATA,  32'h00, "rst_data");
        rst_n = 1'b1;
        tick(6);
        peek_chk(K_FLAGS, 32'h00, "no_false_push_flags");
        core_read(4'h8, 32'h0000_0001, "no_false_push_status");
        core_read(4'h0, 32'h0000_0000, "rx_empty_read");

        // Two host pushes
        host_push(8'hA5);
        peek_chk(K_FLAGS, 32'h08, "push1_ack_toggle");
        host_push(8'h3C);
        peek_chk(K_FLAGS, 32'h00, "push2_ack_toggle");
        core_read(4'h8, 32'h0000_0200, "status_count2");
        core_read(4'h0, 32'h0000_01A5, "rx_byte_a5");
        core_read(4'h0, 32'h0000_013C, "rx_byte_3c");
        core_read(4'h0, 32'h0000_0000, "rx_third_empty");

        // Nine pushes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) host_push(8'h10 + 8'(i));
        peek_chk(K_FLAGS, 32'h0E, "full_ovf_flags");
        core_read(4'h8, 32'h0000_080A, "status_full_ovf");
        core_write(4'h8, 32'h0000_0008);
        core_read(4'h8, 32'h0000_0802, "status_ovf_cleared");

        // Full FIFO: simultaneous push and pop -> pop wins, push dropped
        push_with_read(8'h99, 32'h0000_0110, "full_pushpop_rd");
        core_read(4'h8, 32'h0000_0708, "full_pushpop_status");
        // Non-full: simultaneous push and pop -> count unchanged
        push_with_read(8'hAA, 32'h0000_0111, "pushpop_rd");
        core_read(4'h8, 32'h0000_0708, "pushpop_status");
        core_write(4'h8, 32'h0000_0008);
        for (int i = 2; i < 8; i++) core_read(4'h0, 32'h0000_0110 + 32'(i), "drain_order");
        core_read(4'h0, 32'h0000_01AA, "drain_pushpop_byte");
        core_read(4'h0, 32'h0000_0000, "drain_empty");
        core_read(4'h8, 32'h0000_0001, "drain_status");
        peek_chk(K_FLAGS, 32'h08, "drain_flags");

        // TX handshake
        core_write(4'h4, 32'h0000_005A);
        peek_chk(K_DATA,  32'h5A, "tx_data");
        peek_chk(K_FLAGS, 32'h09, "tx_toggle");
        core_read(4'h8, 32'h0000_0005, "tx_busy");
        core_write(4'h4, 32'h0000_0077);
        peek_chk(K_DATA,  32'h5A, "tx_second_ignored");
        core_read(4'h4, 32'h0000_0000, "txdata_reads_zero");
        ext_flags_i[1] = ~ext_flags_i[1];
        tick(2);
        core_read(4'h8, 32'h0000_0005, "ack_latency_busy");
        core_read(4'h8, 32'h0000_0001, "ack_latency_idle");
        peek_chk(K_FLAGS, 32'h09, "tx_toggle_held");
        core_write(4'h4, 32'h0000_0077);
        peek_chk(K_DATA,  32'h77, "tx2_data");
        peek_chk(K_FLAGS, 32'h08, "tx2_toggle");
        host_ack();
        core_read(4'h8, 32'h0000_0001, "tx2_acked");

`ifdef PULPINO_MBOX_IRQ_EN
        core_write(4'hC, 32'h0000_0001);
        core_read(4'hC, 32'h0000_0001, "irqen_readback");
        peek_chk(K_IRQ, 32'h0, "irq_idle");
        host_push(8'h5C);
        peek_chk(K_IRQ, 32'h1, "irq_rise");
        core_read(4'h0, 32'h0000_015C, "irq_pop");
        peek_chk(K_IRQ, 32'h1, "irq_hold");
        peek_chk(K_IRQ, 32'h0, "irq_fall");
`else
        core_write(4'hC, 32'h0000_0003);
        core_read(4'hC, 32'h0000_0000, "irqen_absent");
        host_push(8'h5C);
        peek_chk(K_IRQ, 32'h0, "irq_tied_low");
        core_read(4'h0, 32'h0000_015C, "noirq_pop");
`endif

        // Reset in the middle of a TX and with a byte queued
        host_push(8'h66);
        core_write(4'h4, 32'h0000_0033);
        peek_chk(K_FLAGS, 32'h09, "pre_rst_flags");
        rst_n = 1'b0;
        peek_chk(K_FLAGS, 32'h00, "midrst_flags");
        peek_chk(K_DATA,  32'h00, "midrst_data");
        rst_n = 1'b1;
        tick(6);
        peek_chk(K_FLAGS, 32'h00, "post_rst_flags");
        core_read(4'h8, 32'h0000_0001, "post_rst_status");
        core_read(4'h0, 32'h0000_0000, "post_rst_rx_empty");
        host_push(8'h81);
        core_read(4'h0, 32'h0000_0181, "post_rst_push");

        tick(3);
        finish_chk = 1'b1;
        for (int i = 0; i < 10 && !drain_done; i++) tick(1);
        if (!drain_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: drain_done=%0b required 1", drain_done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
